key_unexpand: RTL
=================

Name: key_unexpand

Overview:
- Reverse AES-128 key schedule.
- Takes the last round key K10 and walks the schedule backward, one 32-bit word per cycle, to recover W39..W0.
- Presents K0..K10 in the same packed format as the forward expander, plus the recovered cipher key.
- Feeds the decryption datapath, which starts from K10 and consumes keys in reverse order.

Parameters:
- NR, 10, number of AES rounds (fixed for AES-128; other values unsupported).
- WORDS, 44, total schedule words, 4*(NR+1).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous reset, active-high.
- key_valid  input  1  one-cycle pulse: load last_key.
- last_key  input  128  round key K10; word W40 in bits [127:96].
- round_keys  output  [10:0][127:0]  K0..K10 packed; K0 = {W0,W1,W2,W3}.
- cipher_key  output  128  recovered cipher key (equals round_keys[0]).
- keys_valid  output  1  one-cycle pulse when the outputs update.
- busy  output  1  high while a reverse expansion is in progress.

Behaviour:
- Single clock domain. Reset is synchronous and active-high. All state updates on the rising edge of clk.
- Reset:
  - State = IDLE; idx = 0.
  - busy, keys_valid, round_keys, cipher_key and all W registers = 0.
  - rst asserted mid-expansion aborts the run; keys_valid is not pulsed.
- FSM: IDLE -> RUN -> DONE -> IDLE.
- IDLE, key_valid=1 (edge E0):
  - W40..W43 <= last_key.
  - idx <= 39.
  - busy <= 1.
  - Next state RUN.
- RUN, one word per edge (E1..E40):
  - idx%4 != 0: W[idx] <= W[idx+4] ^ W[idx+3].
  - idx%4 == 0: W[idx] <= W[idx+4] ^ SubWord(RotWord(W[idx+3])) ^ {Rcon[(idx+4)/4], 24'h0}.
  - RotWord = left rotate by 8 bits. SubWord = forward S-box applied to each byte. Rcon[1..10] = 01,02,04,08,10,20,40,80,1b,36.
  - idx decrements each edge. After writing W0 at E40, go to DONE.
- DONE (E41):
  - round_keys[r] <= {W4r, W4r+1, W4r+2, W4r+3} for r = 0..10.
  - cipher_key <= {W0..W3}.
  - keys_valid <= 1 for exactly one cycle.
  - busy <= 0.
  - Next state IDLE.
- Latency: keys_valid is visible in the cycle following E41, i.e. 41 edges after key acceptance.
- key_valid while busy=1 is ignored; no queueing and no effect on the run in progress.
- key_valid in the cycle keys_valid is high is accepted, since busy is already low. It starts a new run; the outputs from the finished run hold until that run's DONE.
- round_keys and cipher_key hold their last value between runs. Partial results never appear on the outputs.
- All XORs are 32-bit. idx is 6 bits and never wraps below 0.

Optional Feature:
- Macro: KEY_UNEXPAND_EQ_INV_EN.
- Defined:
  - Adds output dec_round_keys [10:0][127:0] for the Equivalent Inverse Cipher.
  - dec_round_keys[0] = K10; dec_round_keys[i] = InvMixColumns(K(10-i)) for i = 1..9; dec_round_keys[10] = K0.
  - Computed combinationally from the W registers and registered at DONE alongside round_keys, so it updates on the same keys_valid pulse. Resets to 0.
- Undefined: the port and all InvMixColumns logic are absent; other behaviour is identical.

Decomposition:
- Package aes_pkg:
  - constants: SBOX[256], RCON[1:10], NR, NK=4;
  - typedefs: aes_word_t (32b), aes_block_t (128b), round_keys_t ([10:0][127:0]);
  - functions: rot_word, sub_word, inv_mix_columns.
- Sub-module aes_sub_word: four parallel S-box lookups (32b in, 32b out), instanced once for the RotWord path.
- FSM and word update logic stay in key_unexpand.

Test Plan:
- FIPS-197 A.1: key_valid with last_key = d014f9a8c9ee2589e13f0cc8b6630ca6.
  - keys_valid arrives 41 edges later.
  - cipher_key = 2b7e151628aed2a6abf7158809cf4f3c.
  - round_keys[1] = a0fafe1788542cb123a339392a6c7605.
- Round trip: 200 random cipher keys through the forward expander, K10 into key_unexpand. All 11 round_keys match the forward output; one keys_valid pulse per key.
- Busy lockout: second key_valid at E10 with a different key. It is ignored: result matches the first key, busy stays high until E41, and only one keys_valid pulse occurs.
- Back-to-back: key_valid asserted in the keys_valid cycle. A second run starts; the first outputs hold until the second DONE.
- Reset mid-run: rst at E20. busy=0 and keys_valid=0 next cycle, outputs = 0. A new key afterwards completes correctly.
- KEY_UNEXPAND_EQ_INV_EN defined, A.1 vector: dec_round_keys[0] = d014f9a8c9ee2589e13f0cc8b6630ca6, dec_round_keys[10] = 2b7e151628aed2a6abf7158809cf4f3c, and [1..9] match the software InvMixColumns model.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES-128 constants, types and byte/word helpers for the key schedule blocks.
// Includes InvMixColumns, used only when KEY_UNEXPAND_EQ_INV_EN is defined.
package aes_pkg;

  localparam int NR    = 10;
  localparam int NK    = 4;
  localparam int WORDS = NK * (NR + 1);

  typedef logic [31:0]          aes_word_t;
  typedef logic [127:0]         aes_block_t;
  typedef logic [NR:0][127:0]   round_keys_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } ku_state_t;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  localparam logic [7:0] RCON [1:10] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  function automatic aes_word_t rot_word(input aes_word_t w);
    return {w[23:0], w[31:24]};
  endfunction

  function automatic aes_word_t sub_word(input aes_word_t w);
    return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // GF(2^8) multiply by a 4-bit constant (only 9, b, d, e are needed)
  function automatic logic [7:0] gf_mul_k(input logic [7:0] a, input logic [3:0] k);
    logic [7:0] x2;
    logic [7:0] x4;
    logic [7:0] x8;
    x2 = xtime(a);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return (k[0] ? a : 8'h00) ^ (k[1] ? x2 : 8'h00) ^ (k[2] ? x4 : 8'h00) ^ (k[3] ? x8 : 8'h00);
  endfunction

  function automatic aes_word_t inv_mix_word(input aes_word_t w);
    logic [7:0] a0;
    logic [7:0] a1;
    logic [7:0] a2;
    logic [7:0] a3;
    a0 = w[31:24];
    a1 = w[23:16];
    a2 = w[15:8];
    a3 = w[7:0];
    return {gf_mul_k(a0, 4'he) ^ gf_mul_k(a1, 4'hb) ^ gf_mul_k(a2, 4'hd) ^ gf_mul_k(a3, 4'h9),
            gf_mul_k(a0, 4'h9) ^ gf_mul_k(a1, 4'he) ^ gf_mul_k(a2, 4'hb) ^ gf_mul_k(a3, 4'hd),
            gf_mul_k(a0, 4'hd) ^ gf_mul_k(a1, 4'h9) ^ gf_mul_k(a2, 4'he) ^ gf_mul_k(a3, 4'hb),
            gf_mul_k(a0, 4'hb) ^ gf_mul_k(a1, 4'hd) ^ gf_mul_k(a2, 4'h9) ^ gf_mul_k(a3, 4'he)};
  endfunction

  function automatic aes_block_t inv_mix_columns(input aes_block_t s);
    return {inv_mix_word(s[127:96]), inv_mix_word(s[95:64]),
            inv_mix_word(s[63:32]),  inv_mix_word(s[31:0])};
  endfunction

endpackage

// File: rtl/aes_sub_word.sv
// Four parallel forward S-box lookups on a 32-bit word.
module aes_sub_word
  import aes_pkg::*;
(
  input  logic [31:0] i_word,
  output logic [31:0] o_word
);

  assign o_word = sub_word(i_word);

endmodule

// File: rtl/key_unexpand.sv
// Reverse AES-128 key schedule: walks from K10 back to the cipher key, one word per cycle.
// Optional macro KEY_UNEXPAND_EQ_INV_EN adds dec_round_keys for the Equivalent Inverse Cipher.
module key_unexpand
  import aes_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                key_valid,
  input  logic [127:0]        last_key,
  output logic [10:0][127:0]  round_keys,
  output logic [127:0]        cipher_key,
  output logic                keys_valid,
  output logic                busy
`ifdef KEY_UNEXPAND_EQ_INV_EN
  ,
  output logic [10:0][127:0]  dec_round_keys
`endif
);

  ku_state_t   r_state;
  ku_state_t   w_state_next;
  logic [5:0]  r_idx;
  aes_word_t   r_w [WORDS];
  logic        r_busy;
  logic        r_keys_valid;
  round_keys_t r_round_keys;
  aes_block_t  r_cipher_key;

  logic [5:0]  w_idx_far;
  logic [5:0]  w_idx_near;
  aes_word_t   w_far;
  aes_word_t   w_near;
  aes_word_t   w_sub;
  logic [3:0]  w_rcon_sel;
  logic [7:0]  w_rcon;
  aes_word_t   w_new;
  round_keys_t w_keys;

  // W[idx] is rebuilt from W[idx+4] and its forward-schedule neighbour W[idx+3]
  assign w_idx_far  = r_idx + 6'd4;
  assign w_idx_near = r_idx + 6'd3;
  assign w_far      = r_w[w_idx_far];
  assign w_near     = r_w[w_idx_near];
  assign w_rcon_sel = r_idx[5:2] + 4'd1;

  aes_sub_word u_sub_word (
    .i_word (rot_word(w_near)),
    .o_word (w_sub)
  );

  // Round-constant select and recovered word for the current index
  always_comb begin
    w_rcon = 8'h00;
    w_new  = '0;
    if ((w_rcon_sel >= 4'd1) && (w_rcon_sel <= 4'd10)) begin
      w_rcon = RCON[w_rcon_sel];
    end else begin
      w_rcon = 8'h00;
    end
    if (r_idx[1:0] == 2'b00) begin
      w_new = w_far ^ w_sub ^ {w_rcon, 24'h000000};
    end else begin
      w_new = w_far ^ w_near;
    end
  end

  for (genvar g = 0; g <= NR; g++) begin : g_pack
    assign w_keys[g] = {r_w[4*g], r_w[4*g+1], r_w[4*g+2], r_w[4*g+3]};
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (key_valid) begin
          w_state_next = ST_RUN;
        end else begin
          w_state_next = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (r_idx == 6'd0) begin
          w_state_next = ST_DONE;
        end else begin
          w_state_next = ST_RUN;
        end
      end
      ST_DONE: w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Word file, index counter and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx        <= 6'd0;
      r_w          <= '{default: '0};
      r_busy       <= 1'b0;
      r_keys_valid <= 1'b0;
      r_round_keys <= '0;
      r_cipher_key <= '0;
    end else begin
      r_keys_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (key_valid) begin
            r_w[40] <= last_key[127:96];
            r_w[41] <= last_key[95:64];
            r_w[42] <= last_key[63:32];
            r_w[43] <= last_key[31:0];
            r_idx   <= 6'd39;
            r_busy  <= 1'b1;
          end
        end
        ST_RUN: begin
          r_w[r_idx] <= w_new;
          if (r_idx != 6'd0) begin
            r_idx <= r_idx - 6'd1;
          end
        end
        ST_DONE: begin
          r_round_keys <= w_keys;
          r_cipher_key <= w_keys[0];
          r_keys_valid <= 1'b1;
          r_busy       <= 1'b0;
        end
        default: begin
          r_busy <= 1'b0;
        end
      endcase
    end
  end

  assign round_keys = r_round_keys;
  assign cipher_key = r_cipher_key;
  assign keys_valid = r_keys_valid;
  assign busy       = r_busy;

`ifdef KEY_UNEXPAND_EQ_INV_EN
  round_keys_t w_dec;
  round_keys_t r_dec;

  assign w_dec[0]  = w_keys[NR];
  assign w_dec[NR] = w_keys[0];
  for (genvar g = 1; g < NR; g++) begin : g_imc
    assign w_dec[g] = inv_mix_columns(w_keys[NR-g]);
  end

  // Equivalent-inverse keys latch together with round_keys
  always_ff @(posedge clk) begin
    if (rst) begin
      r_dec <= '0;
    end else if (r_state == ST_DONE) begin
      r_dec <= w_dec;
    end else begin
      r_dec <= r_dec;
    end
  end

  assign dec_round_keys = r_dec;
`endif

endmodule
